spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised, second-generation SPI slave front-end for the single-port RAM path. Oversampled in the system clock domain: MOSI and SS_n are sampled on every clk edge.
- Receives a fixed-length frame of (DATA_W+2) bits, MSB first. The top 2 bits are the command; the low DATA_W bits are the address or data.
- Presents the frame to the RAM controller as a parallel word.
- Adds three behaviours: an exact bit counter, a one-cycle rx_valid pulse, and a short-frame error flag.
- For read-data frames, waits for the RAM to supply tx_data, then serialises it on MISO.

Parameters:
- DATA_W, 8, payload width; the frame is DATA_W+2 bits.
- TX_TIMEOUT, 255, clk cycles to wait for tx_valid before abandoning a read (0 = wait forever).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- SS_n  in  1  slave select, active low
- MOSI  in  1  serial data from master
- tx_data  in  DATA_W  read data from RAM
- tx_valid  in  1  tx_data valid, single-cycle pulse
- rx_data  out  DATA_W+2  received frame, command in [DATA_W+1:DATA_W]
- rx_valid  out  1  one-cycle pulse, rx_data valid
- MISO  out  1  serial data to master
- frame_err  out  1  one-cycle pulse: frame aborted early, or TX timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, read_add_done=0, bit counter=0, shift registers=0, timeout counter=0.
  - rx_data=0, rx_valid=0, MISO=0, frame_err=0.
  - Reset overrides everything, including mid-frame and mid-TX.
- States:
  - IDLE: SS_n low -> CHK_CMD.
  - CHK_CMD: samples frame bit DATA_W+1 (MSB) into the shift register and sets the count to 1.
    - MOSI=0 -> WRITE.
    - MOSI=1 and read_add_done=0 -> READ_ADD.
    - MOSI=1 and read_add_done=1 -> READ_DATA.
  - WRITE / READ_ADD / READ_DATA (receive): shift in one MOSI bit per clk.
    - When count reaches DATA_W+2, go to DONE, or TX_WAIT if in READ_DATA.
    - The cycle after the last bit is sampled: rx_valid=1 for exactly one cycle, with rx_data equal to the full shift register.
    - rx_data holds its value until the next rx_valid.
  - TX_WAIT: when tx_valid=1, capture tx_data and go to TX_SHIFT.
    - A timeout counter runs; reaching TX_TIMEOUT pulses frame_err and goes to DONE.
    - tx_valid in any other state is ignored.
  - TX_SHIFT: MISO = captured MSB in the first cycle after capture, then the next bit each clk.
    - After DATA_W bits, MISO=0 and go to DONE.
  - DONE: MOSI ignored and MISO=0; SS_n high -> IDLE.
- read_add_done:
  - Set in the rx_valid cycle of a READ_ADD frame.
  - Cleared in the rx_valid cycle of a READ_DATA frame.
  - Unchanged by aborted frames.
- SS_n high in CHK_CMD or a receive state before the count completes:
  - Next state IDLE; frame_err pulses 1 cycle; no rx_valid.
- SS_n high in TX_WAIT or TX_SHIFT:
  - Next state IDLE; MISO=0 immediately next cycle; captured data discarded.
  - No frame_err, because rx already completed.
- SS_n high in the same cycle the last bit is sampled: the frame counts as complete; rx_valid still pulses; next state IDLE (or TX_WAIT is skipped).
- Back-to-back frames: IDLE->CHK_CMD requires one cycle with SS_n high between frames.
- Bit counter width: $clog2(DATA_W+3).
- MISO and rx_valid are registered outputs, with no combinational path from inputs.

Decomposition:
- Package spi_slave_pkg holds:
  - the state encoding localparams (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE, 3 bits);
  - the command codes (2'b00 wr addr, 2'b01 wr data, 2'b10 rd addr, 2'b11 rd data).
- One natural sub-module: spi_tx_shifter (DATA_W-bit load/shift register with done flag), used for the TX_SHIFT path.

Test Plan:
- Write frame: SS_n low, MOSI 10'b00_1010_0101, then SS_n high -> rx_valid one pulse, rx_data=10'h0A5, no MISO activity, frame_err=0.
- Read-address then read-data: frame 10'b10_0000_0011 -> rx_valid, rx_data=10'h203, read_add_done=1. Next frame 10'b11_0000_0000 -> rx_valid, rx_data=10'h300; drive tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on consecutive cycles; read_add_done=0.
- Short frame: SS_n rises after 6 bits -> frame_err one pulse, rx_valid never asserted, state IDLE, rx_data unchanged.
- TX timeout: TX_TIMEOUT=4, read-data frame, no tx_valid -> frame_err pulse 4 cycles after rx_valid, MISO stays 0.
- Reset mid-TX: rst_n low during the 3rd MISO bit -> next cycle MISO=0, busy=0, read_add_done=0; the following write frame decodes correctly.
- DATA_W=16: 18-bit frame 2'b01 + 16'hBEEF -> rx_data=18'h1BEEF; the bit counter rolls exactly at 18.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Purpose : shared types for the parametrised SPI slave front-end.
// Contents: FSM state encoding, command codes, and width/state helpers.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_TX_WAIT   = 3'd5,
        ST_TX_SHIFT  = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    // Command field carried in the top two frame bits.
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Bit counter must hold values 0..DATA_W+2.
    function automatic int unsigned bit_cnt_width(input int unsigned data_w);
        return $clog2(data_w + 3);
    endfunction

    function automatic logic is_rx_state(input state_e s);
        return (s == ST_WRITE) || (s == ST_READ_ADD) || (s == ST_READ_DATA);
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Purpose : DATA_W-bit load/shift register driving the serial read-data line.
// Ports   : clk, rst_n (sync, active low); load_i/data_i capture a word and
//           present its MSB; shift_i advances one bit; clear_i forces idle;
//           serial_o registered serial bit; done_o high once the LSB is out.
module spi_tx_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              serial_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              serial_q, serial_d;
    logic              done_q;

    // Load presents the MSB immediately; cnt tracks bits still to present.
    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        if (clear_i) begin
            sh_d     = '0;
            cnt_d    = '0;
            serial_d = 1'b0;
        end else if (load_i) begin
            serial_d = data_i[DATA_W-1];
            sh_d     = data_i << 1;
            cnt_d    = CNT_W'(DATA_W - 1);
        end else if (shift_i) begin
            if (cnt_q != '0) begin
                serial_d = sh_q[DATA_W-1];
                sh_d     = sh_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
            end else begin
                serial_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            done_q   <= (cnt_d == '0);
        end
    end

    assign serial_o = serial_q;
    assign done_o   = done_q;

endmodule

// File: rtl/spi_slave_param.sv
// Purpose : oversampled SPI slave front-end for the single-port RAM path.
//           Receives a (DATA_W+2)-bit MSB-first frame, presents it as a
//           parallel word, and serialises RAM read data on MISO.
// Ports   : clk, rst_n (sync, active low); SS_n, MOSI serial inputs;
//           tx_data/tx_valid read data from RAM; rx_data/rx_valid received
//           frame; MISO serial out; frame_err abort/timeout pulse; busy.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              MISO,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = bit_cnt_width(DATA_W);
    localparam int unsigned TO_W    = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TX_TIMEOUT == 0) ? 0 : TX_TIMEOUT - 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0]   shift_q, shift_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 read_add_done_q, read_add_done_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q;
    logic                 last_bit_c;
    logic                 tx_load_c, tx_shift_c, tx_clear_c, tx_done;

    // Count equals FRAME_W-1 while the final frame bit is on MOSI.
    assign last_bit_c = (bit_cnt_q == CNT_W'(FRAME_W - 1));

    // Next-state and datapath control.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        to_d            = '0;
        read_add_done_d = read_add_done_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        frame_err_d     = 1'b0;
        tx_load_c       = 1'b0;
        tx_shift_c      = 1'b0;
        tx_clear_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!SS_n) state_d = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
                if (SS_n) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                end else begin
                    shift_d   = (FRAME_W - 1)'(MOSI);
                    bit_cnt_d = CNT_W'(1);
                    // Command MSB 0 selects the write commands.
                    if (!MOSI)                state_d = ST_WRITE;
                    else if (read_add_done_q) state_d = ST_READ_DATA;
                    else                      state_d = ST_READ_ADD;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (last_bit_c) begin
                    // Final bit completes the frame even if SS_n rises with it.
                    rx_data_d  = {shift_q, MOSI};
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    if (state_q == ST_READ_ADD)  read_add_done_d = 1'b1;
                    if (state_q == ST_READ_DATA) read_add_done_d = 1'b0;
                    if (SS_n)                         state_d = ST_IDLE;
                    else if (state_q == ST_READ_DATA) state_d = ST_TX_WAIT;
                    else                              state_d = ST_DONE;
                end else if (SS_n) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                end else begin
                    shift_d   = {shift_q[FRAME_W-3:0], MOSI};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_TX_WAIT: begin
                if (SS_n) begin
                    state_d    = ST_IDLE;
                    tx_clear_c = 1'b1;
                end else if (tx_valid) begin
                    state_d   = ST_TX_SHIFT;
                    tx_load_c = 1'b1;
                end else if ((TX_TIMEOUT != 0) && (to_q == TO_W'(TO_LAST))) begin
                    state_d     = ST_DONE;
                    frame_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_TX_SHIFT: begin
                if (SS_n || tx_done) begin
                    state_d    = SS_n ? ST_IDLE : ST_DONE;
                    tx_clear_c = 1'b1;
                end else begin
                    tx_shift_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (SS_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            to_q            <= '0;
            read_add_done_q <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            frame_err_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            to_q            <= to_d;
            read_add_done_q <= read_add_done_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            frame_err_q     <= frame_err_d;
            busy_q          <= (state_d != ST_IDLE);
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tx_load_c),
        .shift_i  (tx_shift_c),
        .clear_i  (tx_clear_c),
        .data_i   (tx_data),
        .serial_o (MISO),
        .done_o   (tx_done)
    );

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

    // Receive states and CHK_CMD never coexist with an active transmit word.
    wire unused_ok = is_rx_state(state_q) & 1'b0;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an 8-bit instance (short TX timeout)
// and a 16-bit instance, driven one frame bit per clk.
module tb_spi_slave_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ss8, mosi8, txv8;
    logic [7:0]  txd8;
    logic [9:0]  rxd8;
    logic        rxv8, miso8, fe8, busy8;
    logic        ss16, mosi16, txv16;
    logic [15:0] txd16;
    logic [17:0] rxd16;
    logic        rxv16, miso16, fe16, busy16;

    int n_tests = 0;
    int n_fail  = 0;

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss8), .MOSI(mosi8),
        .tx_data(txd8), .tx_valid(txv8), .rx_data(rxd8), .rx_valid(rxv8),
        .MISO(miso8), .frame_err(fe8), .busy(busy8)
    );

    spi_slave_param #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16),
        .tx_data(txd16), .tx_valid(txv16), .rx_data(rxd16), .rx_valid(rxv16),
        .MISO(miso16), .frame_err(fe16), .busy(busy16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Select, then one bit per clk; returns just after the edge sampling bit n-1.
    task automatic drive8(input logic [9:0] f, input int n, output logic miso_any);
        miso_any = 1'b0;
        ss8 = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            mosi8 = f[9-i];
            step();
            miso_any = miso_any | miso8;
        end
    endtask

    task automatic drive16(input logic [17:0] f, input int n);
        ss16 = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            mosi16 = f[17-i];
            step();
        end
    endtask

    task automatic deselect8();
        ss8 = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss8 = 1'b1; mosi8 = 1'b0; txv8 = 1'b0; txd8 = '0;
        ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; txd16 = '0;
        step(); step();
        n_tests++; if (rxd8 !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data: got %h expected %h", rxd8, 10'h000); end
        n_tests++; if ({rxv8, miso8, fe8, busy8} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {rxv8, miso8, fe8, busy8}); end
        n_tests++; if (rxd16 !== 18'h0) begin n_fail++; $display("FAIL reset_rx_data16: got %h expected 0", rxd16); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        logic ma;
        drive8(10'h0A5, 10, ma);
        n_tests++; if (rxv8 !== 1'b1) begin n_fail++; $display("FAIL write_rx_valid: got %b expected 1", rxv8); end
        n_tests++; if (rxd8 !== 10'h0A5) begin n_fail++; $display("FAIL write_rx_data: got %h expected 0a5", rxd8); end
        n_tests++; if ({ma, miso8, fe8, busy8} !== 4'b0001) begin n_fail++; $display("FAIL write_flags: got %b expected 0001", {ma, miso8, fe8, busy8}); end
        deselect8();
        n_tests++; if ({rxv8, busy8, fe8} !== 3'b000) begin n_fail++; $display("FAIL write_after: got %b expected 000", {rxv8, busy8, fe8}); end
        n_tests++; if (rxd8 !== 10'h0A5) begin n_fail++; $display("FAIL write_hold: got %h expected 0a5", rxd8); end
    endtask

    task automatic test_read();
        logic ma;
        logic [7:0] exp_bits;
        exp_bits = 8'hC3;
        drive8(10'h203, 10, ma);
        n_tests++; if ({rxv8, rxd8} !== {1'b1, 10'h203}) begin n_fail++; $display("FAIL rdaddr_rx: got %b/%h expected 1/203", rxv8, rxd8); end
        n_tests++; if (u_dut8.read_add_done_q !== 1'b1) begin n_fail++; $display("FAIL rdaddr_flag: got %b expected 1", u_dut8.read_add_done_q); end
        deselect8();
        drive8(10'h300, 10, ma);
        n_tests++; if ({rxv8, rxd8, busy8} !== {1'b1, 10'h300, 1'b1}) begin n_fail++; $display("FAIL rddata_rx: got %b/%h/%b expected 1/300/1", rxv8, rxd8, busy8); end
        n_tests++; if (u_dut8.read_add_done_q !== 1'b0) begin n_fail++; $display("FAIL rddata_flag: got %b expected 0", u_dut8.read_add_done_q); end
        txd8 = 8'hC3; txv8 = 1'b1;
        step();
        txv8 = 1'b0; txd8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (miso8 !== exp_bits[7-i]) begin n_fail++; $display("FAIL rd_miso_bit%0d: got %b expected %b", i, miso8, exp_bits[7-i]); end
            step();
        end
        n_tests++; if ({miso8, busy8, fe8} !== 3'b010) begin n_fail++; $display("FAIL rd_tail: got %b expected 010", {miso8, busy8, fe8}); end
        deselect8();
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got %b expected 0", busy8); end
    endtask

    task automatic test_short();
        logic ma;
        drive8(10'h2FF, 6, ma);
        n_tests++; if (rxv8 !== 1'b0) begin n_fail++; $display("FAIL short_no_valid: got %b expected 0", rxv8); end
        deselect8();
        n_tests++; if ({fe8, rxv8, busy8} !== 3'b100) begin n_fail++; $display("FAIL short_err: got %b expected 100", {fe8, rxv8, busy8}); end
        n_tests++; if (rxd8 !== 10'h300) begin n_fail++; $display("FAIL short_hold: got %h expected 300", rxd8); end
        n_tests++; if (u_dut8.read_add_done_q !== 1'b0) begin n_fail++; $display("FAIL short_flag: got %b expected 0", u_dut8.read_add_done_q); end
        step();
        n_tests++; if ({fe8, rxv8} !== 2'b00) begin n_fail++; $display("FAIL short_pulse: got %b expected 00", {fe8, rxv8}); end
    endtask

    task automatic test_last_bit_ss_high();
        logic ma;
        drive8(10'h1C3, 9, ma);
        mosi8 = 1'b1; ss8 = 1'b1;
        step();
        n_tests++; if ({rxv8, rxd8, busy8, fe8} !== {1'b1, 10'h1C3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL lastbit_ss: got %b/%h/%b/%b expected 1/1c3/0/0", rxv8, rxd8, busy8, fe8); end
        step();
        n_tests++; if (rxv8 !== 1'b0) begin n_fail++; $display("FAIL lastbit_pulse: got %b expected 0", rxv8); end
    endtask

    task automatic test_tx_abort();
        logic ma;
        drive8(10'h200, 10, ma);
        deselect8();
        drive8(10'h3FF, 10, ma);
        n_tests++; if ({rxv8, busy8} !== 2'b11) begin n_fail++; $display("FAIL txab_wait: got %b expected 11", {rxv8, busy8}); end
        deselect8();
        n_tests++; if ({fe8, busy8, miso8} !== 3'b000) begin n_fail++; $display("FAIL txab_abort: got %b expected 000", {fe8, busy8, miso8}); end
        txd8 = 8'hFF; txv8 = 1'b1;
        step();
        txv8 = 1'b0;
        step();
        n_tests++; if ({miso8, busy8} !== 2'b00) begin n_fail++; $display("FAIL txab_ignore: got %b expected 00", {miso8, busy8}); end
    endtask

    task automatic test_timeout();
        logic ma;
        drive8(10'h201, 10, ma);
        deselect8();
        drive8(10'h3AA, 10, ma);
        n_tests++; if ({rxv8, rxd8} !== {1'b1, 10'h3AA}) begin n_fail++; $display("FAIL to_rx: got %b/%h expected 1/3aa", rxv8, rxd8); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if ({fe8, miso8} !== 2'b00) begin n_fail++; $display("FAIL to_wait%0d: got %b expected 00", k, {fe8, miso8}); end
            step();
        end
        n_tests++; if ({fe8, miso8, busy8} !== 3'b101) begin n_fail++; $display("FAIL to_err: got %b expected 101", {fe8, miso8, busy8}); end
        txd8 = 8'hFF; txv8 = 1'b1;
        step();
        txv8 = 1'b0;
        n_tests++; if ({fe8, miso8} !== 2'b00) begin n_fail++; $display("FAIL to_after: got %b expected 00", {fe8, miso8}); end
        deselect8();
    endtask

    task automatic test_reset_mid_tx();
        logic ma;
        drive8(10'h205, 10, ma);
        deselect8();
        drive8(10'h305, 10, ma);
        txd8 = 8'hE5; txv8 = 1'b1;
        step();
        txv8 = 1'b0;
        step(); step();
        n_tests++; if (miso8 !== 1'b1) begin n_fail++; $display("FAIL rst_bit3: got %b expected 1", miso8); end
        rst_n = 1'b0; ss8 = 1'b1;
        step();
        n_tests++; if ({miso8, busy8, rxv8} !== 3'b000) begin n_fail++; $display("FAIL rst_outs: got %b expected 000", {miso8, busy8, rxv8}); end
        n_tests++; if ({u_dut8.read_add_done_q, rxd8} !== 11'h000) begin n_fail++; $display("FAIL rst_state: got %b/%h expected 0/000", u_dut8.read_add_done_q, rxd8); end
        rst_n = 1'b1;
        step();
        drive8(10'h15A, 10, ma);
        n_tests++; if ({rxv8, rxd8} !== {1'b1, 10'h15A}) begin n_fail++; $display("FAIL rst_write: got %b/%h expected 1/15a", rxv8, rxd8); end
        deselect8();
    endtask

    task automatic test_wide();
        drive16(18'h1BEEF, 17);
        n_tests++; if ({rxv16, u_dut16.bit_cnt_q} !== {1'b0, 5'd17}) begin n_fail++; $display("FAIL wide_cnt17: got %b/%0d expected 0/17", rxv16, u_dut16.bit_cnt_q); end
        mosi16 = 1'b1;
        step();
        n_tests++; if ({rxv16, rxd16} !== {1'b1, 18'h1BEEF}) begin n_fail++; $display("FAIL wide_rx: got %b/%h expected 1/1beef", rxv16, rxd16); end
        n_tests++; if ({u_dut16.bit_cnt_q, busy16, fe16} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wide_roll: got %0d/%b/%b expected 0/1/0", u_dut16.bit_cnt_q, busy16, fe16); end
        ss16 = 1'b1;
        step();
        drive16(18'h0A55A, 18);
        n_tests++; if ({rxv16, rxd16} !== {1'b1, 18'h0A55A}) begin n_fail++; $display("FAIL wide_b2b: got %b/%h expected 1/0a55a", rxv16, rxd16); end
        ss16 = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_short();
        test_last_bit_ss_high();
        test_tx_abort();
        test_timeout();
        test_reset_mid_tx();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
